// File: rtl/pmem_adapter_pkg.sv
`default_nettype none
// ============================================================================
// pmem_adapter_pkg : shared types and constants for the line-to-word adapter
// Revision: 1.0
// ============================================================================
package pmem_adapter_pkg;

    localparam int LINE_WIDTH  = 128;
    localparam int WORD_WIDTH  = 16;
    localparam int BEATS       = LINE_WIDTH / WORD_WIDTH;
    localparam int BEAT_BITS   = 3;
    localparam int OFFSET_BITS = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RBEAT = 3'd1,
        S_WBEAT = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } adapter_state_t;

endpackage
`default_nettype wire

// File: rtl/pmem_line_adapter.sv
`default_nettype none
// ============================================================================
// pmem_line_adapter : serves 128-bit line reads/writes as eight 16-bit beats
// Revision: 1.0
// ============================================================================
module pmem_line_adapter #(
    parameter int LINE_WIDTH = 128,
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pmem_read_i,
    input  logic                  pmem_write_i,
    input  logic [ADDR_WIDTH-1:0] pmem_address_i,
    input  logic [LINE_WIDTH-1:0] pmem_wdata_i,
    output logic                  pmem_resp_o,
    output logic [LINE_WIDTH-1:0] pmem_rdata_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [WORD_WIDTH-1:0] mem_wdata_o,
    input  logic [WORD_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_resp_i
);
    import pmem_adapter_pkg::*;

    localparam int LINE_ADDR_BITS = ADDR_WIDTH - OFFSET_BITS;

    adapter_state_t              state_q, state_d;
    logic                        is_write_q, is_write_d;
    logic [BEAT_BITS-1:0]        beat_q, beat_d;
    logic [LINE_ADDR_BITS-1:0]   line_q, line_d;
    logic [LINE_WIDTH-1:0]       line_buf_q, line_buf_d;
    logic [LINE_WIDTH-1:0]       pmem_rdata_q, pmem_rdata_d;
    logic                        pmem_resp_q, pmem_resp_d;
    logic                        mem_read_q, mem_read_d;
    logic                        mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0]       mem_address_q, mem_address_d;
    logic [WORD_WIDTH-1:0]       mem_wdata_q, mem_wdata_d;

    // Line-offset bits are dropped: every request is treated as line-aligned.
    logic unused_offset_bits;
    assign unused_offset_bits = ^pmem_address_i[OFFSET_BITS-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            is_write_q    <= 1'b0;
            beat_q        <= '0;
            line_q        <= '0;
            line_buf_q    <= '0;
            pmem_rdata_q  <= '0;
            pmem_resp_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            is_write_q    <= is_write_d;
            beat_q        <= beat_d;
            line_q        <= line_d;
            line_buf_q    <= line_buf_d;
            pmem_rdata_q  <= pmem_rdata_d;
            pmem_resp_q   <= pmem_resp_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        is_write_d   = is_write_q;
        beat_d       = beat_q;
        line_d       = line_q;
        line_buf_d   = line_buf_q;
        pmem_rdata_d = pmem_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (pmem_read_i) begin
                    line_d     = pmem_address_i[ADDR_WIDTH-1:OFFSET_BITS];
                    beat_d     = '0;
                    is_write_d = 1'b0;
                    state_d    = S_RBEAT;
                end else if (pmem_write_i) begin
                    line_d     = pmem_address_i[ADDR_WIDTH-1:OFFSET_BITS];
                    line_buf_d = pmem_wdata_i;
                    beat_d     = '0;
                    is_write_d = 1'b1;
                    state_d    = S_WBEAT;
                end
            end
            S_RBEAT, S_WBEAT: begin
                if (mem_resp_i) begin
                    if (state_q == S_RBEAT) begin
                        line_buf_d[int'(beat_q)*WORD_WIDTH +: WORD_WIDTH] = mem_rdata_i;
                    end
                    if (beat_q == BEAT_BITS'(BEATS-1)) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP:   state_d = is_write_q ? S_WBEAT : S_RBEAT;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so nothing is combinational to a port.
        mem_read_d    = (state_d == S_RBEAT);
        mem_write_d   = (state_d == S_WBEAT);
        pmem_resp_d   = (state_d == S_DONE);
        mem_address_d = {line_d, beat_d, 1'b0};
        mem_wdata_d   = (state_d == S_WBEAT) ?
                        line_buf_d[int'(beat_d)*WORD_WIDTH +: WORD_WIDTH] : '0;
        if ((state_d == S_DONE) && !is_write_q) begin
            pmem_rdata_d = line_buf_d;
        end
    end

    assign pmem_resp_o   = pmem_resp_q;
    assign pmem_rdata_o  = pmem_rdata_q;
    assign mem_read_o    = mem_read_q;
    assign mem_write_o   = mem_write_q;
    assign mem_address_o = mem_address_q;
    assign mem_wdata_o   = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_pmem_line_adapter.sv
`default_nettype none
// ============================================================================
// tb_pmem_line_adapter : directed table-driven bench with a word-memory responder
// Revision: 1.0
// ============================================================================
module tb_pmem_line_adapter;

    localparam int TO = 400;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pmem_read, pmem_write, pmem_resp;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         mem_read, mem_write, mem_resp;
    logic [15:0]  mem_address, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    pmem_line_adapter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pmem_read_i    (pmem_read),
        .pmem_write_i   (pmem_write),
        .pmem_address_i (pmem_address),
        .pmem_wdata_i   (pmem_wdata),
        .pmem_resp_o    (pmem_resp),
        .pmem_rdata_o   (pmem_rdata),
        .mem_read_o     (mem_read),
        .mem_write_o    (mem_write),
        .mem_address_o  (mem_address),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .mem_resp_i     (mem_resp)
    );

    typedef struct {
        bit           rd;
        bit           wr;
        bit           b2b;
        bit           stray;
        logic [15:0]  addr;
        logic [127:0] wdata;
        int           d;
        int           exp_resp;
        int           exp_nr;
        int           exp_nw;
        logic [127:0] exp_rdata;
    } vec_t;

    int ncmp = 0;
    int nfail = 0;

    int           cur_d;
    logic [15:0]  base;
    logic [127:0] cur_wdata;
    bit           cur_stray;
    int           mcnt, k, bbeat, nrb, nwb, nresp, resp_k, first_k, berr;
    bit           gap_due;
    logic [127:0] rdata_at_resp;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] memword(input logic [15:0] a);
        if (a[15:4] == 12'h123) return 16'hA000 + {13'd0, a[3:1]};
        return a ^ 16'h5A5A;
    endfunction

    task automatic clear_stats();
        mcnt = 0; k = 0; bbeat = 0; nrb = 0; nwb = 0; nresp = 0;
        resp_k = -1; first_k = -1; berr = 0; gap_due = 1'b0;
        rdata_at_resp = '0;
    endtask

    // One cycle: observe registered DUT outputs mid-cycle, then act as word memory.
    task automatic step();
        @(negedge clk);
        k++;
        if (gap_due && (mem_read || mem_write)) berr++;
        gap_due = 1'b0;
        if (mem_read && mem_write) berr++;
        if (mem_read || mem_write) begin
            if (first_k < 0) first_k = k;
            if (mem_address !== base + 16'(2 * bbeat)) berr++;
            if (mem_write && (mem_wdata !== cur_wdata[(bbeat & 7) * 16 +: 16])) berr++;
        end
        if (pmem_resp) begin
            nresp++;
            resp_k = k;
            rdata_at_resp = pmem_rdata;
        end
        if (mem_read || mem_write) begin
            mcnt++;
            if (mcnt == cur_d) begin
                mem_resp  = 1'b1;
                mem_rdata = mem_read ? memword(mem_address) : 16'hDEAD;
                mcnt = 0;
                if (mem_read) nrb++; else nwb++;
                bbeat++;
                gap_due = (bbeat < 8);
            end else begin
                mem_resp  = 1'b0;
                mem_rdata = 16'hDEAD;
            end
        end else begin
            mcnt = 0;
            mem_resp  = cur_stray;
            mem_rdata = 16'hBEEF;
        end
    endtask

    // Called at a negedge: that cycle is cycle 0 of the request.
    task automatic run_txn(input vec_t v);
        base      = {v.addr[15:4], 4'h0};
        cur_d     = v.d;
        cur_wdata = v.wdata;
        cur_stray = v.stray;
        clear_stats();
        pmem_read    = v.rd;
        pmem_write   = v.wr;
        pmem_address = v.addr;
        pmem_wdata   = v.wdata;
        for (int n = 0; n < TO; n++) begin
            step();
            if (k == 2) begin
                pmem_address = ~v.addr;
                pmem_wdata   = ~v.wdata;
            end
            if (resp_k >= 0 && k == resp_k + 1) begin
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
                break;
            end
        end
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
    endtask

    task automatic check_vec(input vec_t v);
        chk("resp_cycle", 128'(resp_k), 128'(v.exp_resp));
        chk("resp_count", 128'(nresp), 128'd1);
        chk("read_beats", 128'(nrb), 128'(v.exp_nr));
        chk("write_beats", 128'(nwb), 128'(v.exp_nw));
        chk("beat_addr_data_gap_errors", 128'(berr), 128'd0);
        chk("first_beat_cycle", 128'(first_k), 128'd1);
        if (v.rd) chk("rdata_at_resp", rdata_at_resp, v.exp_rdata);
        chk("rdata_held", pmem_rdata, v.exp_rdata);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{rd:1, wr:0, b2b:0, stray:0, addr:16'h1234, wdata:'0, d:1,
                    exp_resp:16, exp_nr:8, exp_nw:0,
                    exp_rdata:128'hA007_A006_A005_A004_A003_A002_A001_A000};
        vecs[1] = '{rd:0, wr:1, b2b:0, stray:0, addr:16'h4000,
                    wdata:128'h0007_0006_0005_0004_0003_0002_0001_0000, d:3,
                    exp_resp:32, exp_nr:0, exp_nw:8,
                    exp_rdata:128'hA007_A006_A005_A004_A003_A002_A001_A000};
        vecs[2] = '{rd:1, wr:1, b2b:0, stray:0, addr:16'h2000, wdata:{8{16'hFFFF}}, d:2,
                    exp_resp:24, exp_nr:8, exp_nw:0,
                    exp_rdata:128'h7A54_7A56_7A50_7A52_7A5C_7A5E_7A58_7A5A};
        vecs[3] = '{rd:1, wr:0, b2b:0, stray:0, addr:16'h0000, wdata:'0, d:1,
                    exp_resp:16, exp_nr:8, exp_nw:0,
                    exp_rdata:128'h5A54_5A56_5A50_5A52_5A5C_5A5E_5A58_5A5A};
        vecs[4] = '{rd:0, wr:1, b2b:1, stray:0, addr:16'h0010,
                    wdata:128'h1111_2222_3333_4444_5555_6666_7777_8888, d:1,
                    exp_resp:16, exp_nr:0, exp_nw:8,
                    exp_rdata:128'h5A54_5A56_5A50_5A52_5A5C_5A5E_5A58_5A5A};
        vecs[5] = '{rd:1, wr:0, b2b:0, stray:1, addr:16'hFFFF, wdata:'0, d:2,
                    exp_resp:24, exp_nr:8, exp_nw:0,
                    exp_rdata:128'hA5A4_A5A6_A5A0_A5A2_A5AC_A5AE_A5A8_A5AA};

        rst_n = 1'b0;
        pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0; pmem_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        cur_d = 1; base = '0; cur_wdata = '0; cur_stray = 1'b0;
        clear_stats();
        repeat (3) step();
        chk("reset_outputs", {pmem_resp, mem_read, mem_write, mem_address, mem_wdata}, '0);
        chk("reset_rdata", pmem_rdata, '0);
        rst_n = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i]);
            if (!(i + 1 < 6 && vecs[i + 1].b2b)) repeat (4) step();
            check_vec(vecs[i]);
        end

        // Reset asserted asynchronously while beat 4 of a read is outstanding.
        cur_stray = 1'b0;
        cur_d = 3; base = 16'h1230; cur_wdata = '0;
        clear_stats();
        pmem_read = 1'b1; pmem_address = 16'h1234;
        for (int n = 0; n < TO; n++) begin
            step();
            if (bbeat == 4 && mem_read) break;
        end
        chk("reached_beat4", 128'(bbeat), 128'd4);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", {pmem_resp, mem_read, mem_write, mem_address, mem_wdata}, '0);
        chk("rst_async_rdata", pmem_rdata, '0);
        pmem_read = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        clear_stats();
        repeat (20) step();
        chk("post_rst_resp", 128'(nresp), 128'd0);
        chk("post_rst_beats", 128'(nrb + nwb + first_k + 1), 128'd0);

        run_txn(vecs[0]);
        repeat (4) step();
        check_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pmem_line_adapter.md
# pmem_line_adapter

Synthesizable responder for the 128-bit cache-line physical-memory interface driven by the `mp3` core. It accepts one line read or line write on that interface and performs it as eight sequential 16-bit word transactions on a narrow word-wide memory port. The adapter replaces the behavioural line memory when the core is mapped onto a word-organised RAM or controller. Because it is the memory side of the line interface, it must satisfy the core's hold-until-resp handshake exactly.

## Interface
- `LINE_WIDTH`, default 128: line width in bits. Only the default is supported and verified.
- `WORD_WIDTH`, default 16: downstream word width in bits. `BEATS = LINE_WIDTH/WORD_WIDTH = 8`.
- `ADDR_WIDTH`, default 16: byte address width on both ports.
- `clk`  in  1  system clock. All state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pmem_read`  in  1  line read request. Held high until `pmem_resp`.
- `pmem_write`  in  1  line write request. Held high until `pmem_resp`.
- `pmem_address`  in  16  byte address. Bits [3:0] are ignored, so requests are always line-aligned.
- `pmem_wdata`  in  128  write line. Word i is bits [16i+15:16i].
- `pmem_resp`  out  1  one-cycle completion pulse.
- `pmem_rdata`  out  128  read line. Valid in the `pmem_resp` cycle and held until the next read completes.
- `mem_read`  out  1  word read request. Held until `mem_resp`.
- `mem_write`  out  1  word write request. Held until `mem_resp`.
- `mem_address`  out  16  word byte address: {line, beat[2:0], 1'b0}.
- `mem_wdata`  out  16  write word for the current beat.
- `mem_rdata`  in  16  read word. Sampled on the edge where `mem_resp` is high.
- `mem_resp`  in  1  one-cycle word completion.

## Operation
- States: IDLE, RBEAT, WBEAT, GAP, DONE.
- IDLE:
  - `pmem_read` high: latch line address, clear beat, go to RBEAT.
  - else `pmem_write` high: latch address and `pmem_wdata`, clear beat, go to WBEAT.
  - If both are high, the read wins. The write is not performed.
- RBEAT and WBEAT:
  - `mem_read` (respectively `mem_write`) is high, and `mem_address`/`mem_wdata` reflect the current beat.
  - On `mem_resp`, a read stores `mem_rdata` into line slot `beat`.
  - If beat == 7, go to DONE. Otherwise increment beat and go to GAP.
- GAP: one cycle with both `mem_read` and `mem_write` low. Then return to the RBEAT/WBEAT state that was in progress.
- DONE: `pmem_resp` = 1 for exactly one cycle. A read also updates `pmem_rdata` with the assembled line. Next state is IDLE.
- Beat order is ascending, words 0..7. Address arithmetic never carries out of the latched line.
- `mem_resp` is ignored in IDLE, GAP and DONE.
- Changes on `pmem_*` inputs after the request is accepted are ignored until IDLE.
- Reset, whether asserted mid-transaction or not:
  - Next state is IDLE and the beat counter is 0.
  - `pmem_resp`, `mem_read` and `mem_write` are 0; `mem_address`, `mem_wdata` and `pmem_rdata` are 0.
  - Any in-flight downstream word is abandoned and no `pmem_resp` is issued.

## Timing
- Cycle 0 is the cycle in which the request is first sampled high in IDLE.
- Let D ≥ 1 be the downstream latency: `mem_resp` is high in the D-th cycle of a request's assertion.
- Beat b is requested in cycles 1+b(D+1) through D+b(D+1). GAP follows each beat except beat 7.
- `pmem_resp` is high in cycle 8D+8. With D = 1 that is cycle 16.
- The core drops its request in the cycle after `pmem_resp`. Because DONE→IDLE takes one cycle, no spurious retrigger occurs.
- Back-to-back requests: the earliest next acceptance is cycle 8D+9.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `pmem_adapter_pkg` contains:
  - the state enum `adapter_state_t`;
  - the constants `LINE_WIDTH`, `WORD_WIDTH`, `BEATS`, `BEAT_BITS = 3`, `OFFSET_BITS = 4`.
- The adapter is a single module. The line buffer is a 128-bit register indexed by beat, shared by read assembly and write data.
- No sub-module.

## Test plan
- **Line read:** D = 1, memory word at byte addr 0x1230+2i = 0xA000+i; `pmem_read`, addr 0x1234. Required:
  - eight `mem_read` beats at 0x1230..0x123E, each followed by a GAP;
  - `pmem_resp` in cycle 16;
  - `pmem_rdata` = 0xA007_A006_…_A000.
- **Line write:** `pmem_write`, addr 0x4000, `pmem_wdata` = 0x0007_0006_…_0000, D = 3. Required:
  - `mem_write` at 0x4000+2i with `mem_wdata` = i;
  - `pmem_resp` in cycle 32 only.
- **Simultaneous request:** `pmem_read` and `pmem_write` both high. Required: only `mem_read` beats, `mem_write` never asserts, exactly one `pmem_resp`.
- **Back-to-back:** read 0x0000, then write 0x0010 accepted in the cycle after the core drops its read. Required:
  - the second transaction starts at cycle 8D+9;
  - `pmem_rdata` still holds the first line after the write completes.
- **Reset mid-beat:** assert `rst_n` = 0 during beat 4 of a read. Required:
  - all outputs are 0 immediately (asynchronously);
  - after release, IDLE with no `pmem_resp`;
  - a new read completes correctly.
- **Stray `mem_resp`:** pulse `mem_resp` while in IDLE and in GAP. Required: no state change, no beat advance.
